fp_add_pipe: RTL and testbench
==============================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 The block SHALL have a parameter EXP_W, default 5, giving the exponent width.
REQ-002 The block SHALL have a parameter MAN_W, default 10, giving the stored fraction width. The operand and result width is W = 1+EXP_W+MAN_W.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  an input operation is presented.
REQ-006 ready_o  output  1  the block accepts the input operation this cycle.
REQ-007 opA_i, opB_i  input  W  IEEE-style operands {sign, exponent, fraction}.
REQ-008 sub_i  input  1  when 1, the block computes A-B by inverting the sign of B.
REQ-009 rnd_i  input  1  rounding mode: 0 = truncate toward zero, 1 = round-to-nearest-even.
REQ-010 valid_o  output  1  a result is presented.
REQ-011 ready_i  input  1  downstream accepts the result.
REQ-012 ADD_o  output  W  the result.
REQ-013 flags_o  output  3  {invalid, overflow, inexact}, aligned with ADD_o.

Function
REQ-014 The pipeline SHALL have 3 register stages: S1 unpack/compare/align, S2 add/subtract, S3 normalize/round/pack. Latency SHALL be 3 cycles from acceptance to valid_o with no stalls.
REQ-015 Global advance SHALL be en = ready_i | ~valid_o. ready_o SHALL equal en, and all stages SHALL shift only when en=1.
REQ-016 An input SHALL be accepted when valid_i & ready_o. While en=0, every stage register, valid_o, ADD_o and flags_o SHALL hold.
REQ-017 Bubbles SHALL propagate as invalid stages. They need not be collapsed.
REQ-018 sub_i and rnd_i SHALL be captured with their operands and travel down the pipeline with them.
REQ-019 Alignment SHALL treat denormals (exponent 0) as 0.fraction with an effective exponent of 1.
REQ-020 The smaller operand SHALL be right-shifted by the exponent difference. Shifted-out bits SHALL feed guard, round and sticky bits.
REQ-021 Shift amounts of MAN_W+3 or more SHALL reduce that operand to sticky only.
REQ-022 For an effective add, a mantissa carry-out SHALL shift the result right 1 and increment the exponent.
REQ-023 For an effective subtract, the larger magnitude SHALL be minuend and the result SHALL take its sign.
REQ-024 Normalization SHALL left-shift by the leading-zero count, limited so the exponent does not fall below 1. A limited result SHALL be packed as a denormal (gradual underflow).
REQ-025 RNE SHALL round up when guard=1 and (round|sticky|lsb)=1. A rounding carry SHALL renormalize the result.
REQ-026 Truncate mode SHALL discard guard, round and sticky.
REQ-027 inexact SHALL be set when guard|round|sticky is nonzero after normalization.
REQ-028 An exact zero from cancellation SHALL be +0. The sum of two zeros SHALL have sign signA & signB_eff.
REQ-029 A zero operand SHALL return the other operand exactly, with flags 0.
REQ-030 An exponent of all ones with fraction 0 SHALL be infinity. With fraction nonzero it SHALL be NaN.
REQ-031 Any NaN input SHALL give quiet NaN {0, all-ones exponent, fraction MSB 1, rest 0}, with invalid=0.
REQ-032 Infinity plus infinity of opposite effective sign SHALL give quiet NaN with invalid=1.
REQ-033 Infinity plus finite, or infinities of the same sign, SHALL give that infinity with flags 0.
REQ-034 When a finite result exponent reaches all ones after rounding, the output SHALL be infinity of the result sign with overflow=1 and inexact=1, in both rounding modes.

Reset
REQ-035 While rst_i=1, all stage valid bits and valid_o SHALL be 0, and ADD_o and flags_o SHALL be 0.
REQ-036 Reset mid-operation SHALL discard every in-flight operation. No result SHALL emerge after reset release until a new input is accepted.
REQ-037 ready_o SHALL be 1 from the first cycle after reset deassertion.

Verification (FP16 defaults, ready_i=1 unless stated)
REQ-038 0x3C00 + 0x3C00, rnd=1 -> ADD_o=0x4000, flags=000, exactly 3 cycles later.
REQ-039 0x3C00 + 0x3C03: rnd=1 -> 0x4002, flags=001; rnd=0 -> 0x4001, flags=001.
REQ-040 0x7BFF + 0x7BFF -> 0x7C00, flags=011. 0x7C00 + 0xFC00 -> 0x7E00, flags=100.
REQ-041 0x3C00 with sub_i=1 on 0x3C00 -> 0x0000. 0x0400 with sub_i=1 on 0x0001 -> 0x03FF, flags=000.
REQ-042 Back-to-back inputs, then ready_i=0 for 5 cycles:
- ready_o SHALL be 0 and outputs SHALL be held.
- Results SHALL emerge in order with none lost or duplicated.
- rst_i pulsed mid-stream SHALL give valid_o=0 and no stale results afterward.

Source files
------------

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with a single global advance.
// S1 unpack/compare/align, S2 add/subtract, S3 normalize/round/pack.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] opA_i,
  input  logic [W-1:0] opB_i,
  input  logic         sub_i,
  input  logic         rnd_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] ADD_o,
  output logic [2:0]   flags_o
);
  localparam int unsigned MW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned MR = MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;

  // Stage registers
  logic             v1_q, spec1_q, sign1_q, esub1_q, rnd1_q;
  logic [W-1:0]     spec_res1_q;
  logic [2:0]       spec_flags1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [MW-1:0]    big1_q, small1_q;

  logic             v2_q, spec2_q, sign2_q, rnd2_q;
  logic [W-1:0]     spec_res2_q;
  logic [2:0]       spec_flags2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [MW:0]      sum2_q;

  logic             valid_q;
  logic [W-1:0]     res_q;
  logic [2:0]       flags_q;

  assign en      = ready_i | ~valid_q;
  assign ready_o = en;
  assign valid_o = valid_q;
  assign ADD_o   = res_q;
  assign flags_o = flags_q;

  // S1: classify, pick the larger magnitude, align the smaller one
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, e_big, e_small, e_diff;
  logic [MAN_W:0]   ma, mb, m_small;
  logic [MW-1:0]    big_ext, small_ext, small_sh, lost_mask;
  logic             s1_spec;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flags;

  always_comb begin
    sa      = opA_i[W-1];
    sb      = opB_i[W-1] ^ sub_i;
    ea      = opA_i[W-2:MAN_W];
    eb      = opB_i[W-2:MAN_W];
    ma      = {ea != '0, opA_i[MAN_W-1:0]};
    mb      = {eb != '0, opB_i[MAN_W-1:0]};
    a_nan   = (ea == EMAX) && (opA_i[MAN_W-1:0] != '0);
    b_nan   = (eb == EMAX) && (opB_i[MAN_W-1:0] != '0);
    a_inf   = (ea == EMAX) && (opA_i[MAN_W-1:0] == '0);
    b_inf   = (eb == EMAX) && (opB_i[MAN_W-1:0] == '0);
    a_zero  = (opA_i[W-2:0] == '0);
    b_zero  = (opB_i[W-2:0] == '0);
    ea_eff  = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff  = (eb == '0) ? EXP_W'(1) : eb;
    a_big   = opA_i[W-2:0] >= opB_i[W-2:0];
    e_big   = a_big ? ea_eff : eb_eff;
    e_small = a_big ? eb_eff : ea_eff;
    m_small = a_big ? mb : ma;
    big_ext = {a_big ? ma : mb, 3'b000};
    e_diff  = e_big - e_small;

    small_ext = {m_small, 3'b000};
    lost_mask = '0;
    small_sh  = '0;
    if (32'(e_diff) >= MAN_W + 3) begin
      small_sh = {{(MW-1){1'b0}}, |m_small};
    end else begin
      lost_mask   = (MW'(1) << e_diff) - MW'(1);
      small_sh    = small_ext >> e_diff;
      small_sh[0] = small_sh[0] | (|(small_ext & lost_mask));
    end

    s1_spec       = 1'b1;
    s1_spec_res   = '0;
    s1_spec_flags = '0;
    if (a_nan || b_nan) begin
      s1_spec_res = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_spec_res   = QNAN;
      s1_spec_flags = 3'b100;
    end else if (a_inf) begin
      s1_spec_res = opA_i;
    end else if (b_inf) begin
      s1_spec_res = {sb, opB_i[W-2:0]};
    end else if (a_zero && b_zero) begin
      s1_spec_res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_spec_res = {sb, opB_i[W-2:0]};
    end else if (b_zero) begin
      s1_spec_res = opA_i;
    end else begin
      s1_spec = 1'b0;
    end
  end

  // S2: big >= small in magnitude, so subtraction never goes negative
  logic [MW:0] sum2_d;
  always_comb begin
    sum2_d = esub1_q ? ({1'b0, big1_q} - {1'b0, small1_q})
                     : ({1'b0, big1_q} + {1'b0, small1_q});
  end

  // S3: normalize (carry right, or left limited to exponent 1), round, pack
  logic [MW-1:0]    nm;
  logic [EW-1:0]    e_n, e_r;
  int unsigned      lz, lim, shamt;
  logic             inc, inexact;
  logic [MR-1:0]    mr;
  logic [W-1:0]     res_d;
  logic [2:0]       flags_d;

  always_comb begin
    lz = MW;
    for (int i = 0; i < int'(MW); i++) begin
      if (sum2_q[i]) lz = MW - 1 - unsigned'(i);
    end
    e_n   = EW'(exp2_q);
    nm    = '0;
    lim   = 0;
    shamt = 0;
    if (sum2_q[MW]) begin
      nm    = sum2_q[MW:1];
      nm[0] = sum2_q[1] | sum2_q[0];
      e_n   = e_n + EW'(1);
    end else begin
      lim   = 32'(exp2_q) - 1;
      shamt = (lz < lim) ? lz : lim;
      nm    = sum2_q[MW-1:0] << shamt;
      e_n   = e_n - EW'(shamt);
    end

    inc     = rnd2_q & nm[2] & (nm[1] | nm[0] | nm[3]);
    inexact = |nm[2:0];
    mr      = {1'b0, nm[MW-1:3]} + MR'(inc);
    e_r     = e_n;
    if (mr[MR-1]) begin
      mr  = mr >> 1;
      e_r = e_n + EW'(1);
    end

    if (spec2_q) begin
      res_d   = spec_res2_q;
      flags_d = spec_flags2_q;
    end else if (sum2_q == '0) begin
      res_d   = '0;
      flags_d = '0;
    end else if (e_r >= EW'(EMAX)) begin
      res_d   = {sign2_q, EMAX, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end else begin
      res_d   = {sign2_q, mr[MAN_W] ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}, mr[MAN_W-1:0]};
      flags_d = {2'b00, inexact};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q          <= 1'b0;
      spec1_q       <= 1'b0;
      sign1_q       <= 1'b0;
      esub1_q       <= 1'b0;
      rnd1_q        <= 1'b0;
      spec_res1_q   <= '0;
      spec_flags1_q <= '0;
      exp1_q        <= '0;
      big1_q        <= '0;
      small1_q      <= '0;
      v2_q          <= 1'b0;
      spec2_q       <= 1'b0;
      sign2_q       <= 1'b0;
      rnd2_q        <= 1'b0;
      spec_res2_q   <= '0;
      spec_flags2_q <= '0;
      exp2_q        <= '0;
      sum2_q        <= '0;
      valid_q       <= 1'b0;
      res_q         <= '0;
      flags_q       <= '0;
    end else if (en) begin
      v1_q <= valid_i;
      if (valid_i) begin
        spec1_q       <= s1_spec;
        spec_res1_q   <= s1_spec_res;
        spec_flags1_q <= s1_spec_flags;
        sign1_q       <= a_big ? sa : sb;
        esub1_q       <= sa ^ sb;
        rnd1_q        <= rnd_i;
        exp1_q        <= e_big;
        big1_q        <= big_ext;
        small1_q      <= small_sh;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        spec2_q       <= spec1_q;
        spec_res2_q   <= spec_res1_q;
        spec_flags2_q <= spec_flags1_q;
        sign2_q       <= sign1_q;
        rnd2_q        <= rnd1_q;
        exp2_q        <= exp1_q;
        sum2_q        <= sum2_d;
      end
      valid_q <= v2_q;
      if (v2_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe (FP16): directed vectors, random traffic against an exact-arithmetic
// reference, backpressure hold and mid-stream reset.
module tb_fp_add_pipe;
  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_i, valid_i, ready_o, sub_i, rnd_i, valid_o, ready_i;
  logic [W-1:0] opA_i, opB_i, ADD_o;
  logic [2:0]   flags_o;

  int total = 0;
  int bad = 0;
  logic [18:0] sb_q[$];  // {flags, result} expected, in acceptance order

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .opA_i  (opA_i),
    .opB_i  (opB_i),
    .sub_i  (sub_i),
    .rnd_i  (rnd_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .ADD_o  (ADD_o),
    .flags_o(flags_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Exact sum in units of 2^-24, then rounded to FP16 by integer arithmetic.
  function automatic logic [18:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic r);
    logic   sa, sb, sign;
    int     ea, eb, e;
    longint va, vb, sum, mag, q, m, rem;
    sa = a[15];
    sb = b[15] ^ s;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return {3'b000, 16'h7E00};
    if (ea == 31 && eb == 31 && sa != sb) return {3'b100, 16'h7E00};
    if (ea == 31) return {3'b000, a};
    if (eb == 31) return {3'b000, sb, b[14:0]};
    if (a[14:0] == 0 && b[14:0] == 0) return {3'b000, sa & sb, 15'h0};
    if (a[14:0] == 0) return {3'b000, sb, b[14:0]};
    if (b[14:0] == 0) return {3'b000, a};
    va = (ea != 0) ? longint'(a[9:0]) + 1024 : longint'(a[9:0]);
    vb = (eb != 0) ? longint'(b[9:0]) + 1024 : longint'(b[9:0]);
    va = va << ((ea != 0) ? ea - 1 : 0);
    vb = vb << ((eb != 0) ? eb - 1 : 0);
    sum = (sa ? -va : va) + (sb ? -vb : vb);
    if (sum == 0) return 19'h0;
    sign = (sum < 0);
    mag  = sign ? -sum : sum;
    e = 1;
    while (mag >= (longint'(2048) << (e - 1))) e++;
    q   = longint'(1) << (e - 1);
    m   = mag >> (e - 1);
    rem = mag & (q - 1);
    if (r && ((2 * rem > q) || (2 * rem == q && m[0]))) m++;
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e >= 31) return {3'b011, sign, 5'h1F, 10'h0};
    return {2'b00, rem != 0, sign, (m >= 1024) ? 5'(e) : 5'd0, 10'(m)};
  endfunction

  function automatic logic [15:0] rand_op(input logic [15:0] other);
    logic [15:0] v;
    int          e;
    v = 16'($urandom);
    case ($urandom_range(0, 11))
      0: v[14:0] = '0;
      1: v[14:0] = 15'h7C00;
      2: v[14:10] = 5'h1F;
      3: v[14:10] = 5'h00;
      4, 5, 6: begin
        e = int'(other[14:10]) + int'($urandom_range(0, 2)) - 1;
        if (e < 0) e = 0;
        if (e > 30) e = 30;
        v[14:10] = 5'(e);
        if ($urandom_range(0, 1) == 1) v[9:3] = other[9:3];
      end
      7: v[14:10] = 5'h1E;
      default: if (v[14:10] == 5'h1F) v[14:10] = 5'h1E;
    endcase
    return v;
  endfunction

  // Called at a falling edge with inputs set; scores the transfers of the next rising edge.
  task automatic tick();
    logic [18:0] e;
    #1;
    if (valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check("spurious valid_o", 32'(valid_o), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", 32'(ADD_o), 32'(e[15:0]));
        check("flags", 32'(flags_o), 32'(e[18:16]));
      end
    end
    if (valid_i && ready_o) sb_q.push_back(ref_add(opA_i, opB_i, sub_i, rnd_i));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic r, input logic [15:0] want,
                          input logic [2:0] want_fl);
    int n = 0;
    ready_i = 1'b1;
    opA_i = a;
    opB_i = b;
    sub_i = s;
    rnd_i = r;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    while (!valid_o && n < 10) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " result"}, 32'(ADD_o), 32'(want));
    check({tag, " flags"}, 32'(flags_o), 32'(want_fl));
    tick();
  endtask

  task automatic load_random();
    opA_i = rand_op(opB_i);
    opB_i = rand_op(opA_i);
    sub_i = 1'($urandom);
    rnd_i = 1'($urandom);
  endtask

  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    opA_i = '0;
    opB_i = '0;
    sub_i = 1'b0;
    rnd_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset ADD_o", 32'(ADD_o), 32'd0);
    check("reset flags_o", 32'(flags_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready after reset", 32'(ready_o), 32'd1);

    directed("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000, 3'b000);
    directed("rne_tie", 16'h3C00, 16'h3C03, 1'b0, 1'b1, 16'h4002, 3'b001);
    directed("truncate", 16'h3C00, 16'h3C03, 1'b0, 1'b0, 16'h4001, 3'b001);
    directed("overflow", 16'h7BFF, 16'h7BFF, 1'b0, 1'b1, 16'h7C00, 3'b011);
    directed("inf_minus_inf", 16'h7C00, 16'hFC00, 1'b0, 1'b1, 16'h7E00, 3'b100);
    directed("cancel", 16'h3C00, 16'h3C00, 1'b1, 1'b1, 16'h0000, 3'b000);
    directed("gradual_underflow", 16'h0400, 16'h0001, 1'b1, 1'b1, 16'h03FF, 3'b000);
    directed("nan_in", 16'h7C01, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 3'b000);
    directed("zero_operand", 16'h0000, 16'h3555, 1'b1, 1'b1, 16'hB555, 3'b000);
    directed("inf_plus_finite", 16'hFC00, 16'h7BFF, 1'b0, 1'b0, 16'hFC00, 3'b000);

    // Back-to-back, then a 5-cycle stall with new input held at the port
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_random();
      valid_i = 1'b1;
      tick();
    end
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_random();
      #1;
      check("stall ready_o", 32'(ready_o), 32'd0);
      check("stall valid_o", 32'(valid_o), 32'd1);
      check("stall hold result", 32'(ADD_o), 32'(sb_q[0][15:0]));
      check("stall hold flags", 32'(flags_o), 32'(sb_q[0][18:16]));
      tick();
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      load_random();
      valid_i = ($urandom_range(0, 6) != 0);
      ready_i = ($urandom_range(0, 4) != 0);
      tick();
    end
    drain();

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      load_random();
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("mid reset valid_o", 32'(valid_o), 32'd0);
    check("mid reset ADD_o", 32'(ADD_o), 32'd0);
    check("mid reset flags_o", 32'(flags_o), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post reset idle", 32'(valid_o), 32'd0);
      tick();
    end
    directed("after_reset", 16'h3C00, 16'h4000, 1'b0, 1'b1, 16'h4200, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
